mux21_rr_sched: RTL

//  Round-robin scheduler for the 2:1 2-bit valid mux (mux21_2b). Arbitrates in0_valid/in1_valid,

---
 rtl/mux21_rr_sched.sv | 95 +++++++++
 1 files changed

// File: rtl/mux21_rr_sched.sv
// Round-robin scheduler for the 2:1 2-bit valid mux: arbitrates two sources with bounded bursts.
// Optional per-source saturating grant counters are built when MUX_SCHED_STATS_EN is defined.
module mux21_rr_sched #(
    parameter int MAX_BURST = 2,
    parameter int BURST_W   = 2
`ifdef MUX_SCHED_STATS_EN
    ,
    parameter int CNT_W     = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in0_valid,
    input  logic             in1_valid,
    input  logic             stall,
    output logic             select,
    output logic             ack0,
    output logic             ack1,
    output logic             busy
`ifdef MUX_SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);

    logic               owner_q, owner_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [1:0]         valid;
    logic               own_v, oth_v;
    logic               grant_own, grant_oth;

    // Reset gates grants combinationally so a mid-burst reset stops acks without waiting for an edge.
    always_comb begin
        valid     = {in1_valid, in0_valid};
        own_v     = valid[owner_q];
        oth_v     = valid[~owner_q];
        grant_own = !reset && !stall && own_v && ((burst_q < MAX_B) || !oth_v);
        grant_oth = !reset && !stall && !grant_own && oth_v;
        select    = grant_oth ? ~owner_q : owner_q;
        ack0      = (grant_own && !owner_q) || (grant_oth && owner_q);
        ack1      = (grant_own && owner_q) || (grant_oth && !owner_q);
        busy      = ack0 | ack1;
    end

    always_comb begin
        owner_d = owner_q;
        burst_d = burst_q;
        if (grant_own) begin
            burst_d = (burst_q >= MAX_B) ? MAX_B : burst_q + BURST_W'(1);
        end else if (grant_oth) begin
            owner_d = ~owner_q;
            burst_d = BURST_W'(1);
        end else if (!stall) begin
            burst_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= 1'b0;
            burst_q <= '0;
        end else begin
            owner_q <= owner_d;
            burst_q <= burst_d;
        end
    end

`ifdef MUX_SCHED_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (ack0 && (cnt0_q != '1)) cnt0_d = cnt0_q + CNT_W'(1);
        if (ack1 && (cnt1_q != '1)) cnt1_d = cnt1_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule
